// File: rtl/avmm_debounced_pio.sv
// Avalon-MM parallel I/O peripheral: one debounced input bank with per-bit
// edge capture and a maskable level interrupt, and one output bank with
// atomic set/clear access. Single clock domain, asynchronous active-low reset.
module avmm_debounced_pio #(
    parameter int unsigned IN_WIDTH        = 18,
    parameter int unsigned OUT_WIDTH       = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [31:0] IN_RESET        = 32'h0,
    parameter logic [31:0] OUT_RESET       = 32'h0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);

    typedef enum logic [2:0] {
        ADDR_DATA_IN      = 3'd0,
        ADDR_DATA_OUT     = 3'd1,
        ADDR_OUT_SET      = 3'd2,
        ADDR_OUT_CLR      = 3'd3,
        ADDR_IRQ_MASK     = 3'd4,
        ADDR_EDGE_CAPTURE = 3'd5,
        ADDR_EDGE_MODE    = 3'd6,
        ADDR_ID           = 3'd7
    } addr_e;

    // A 1-cycle debounce period still needs a 1-bit counter.
    localparam int unsigned          PRESC_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IN_WIDTH-1:0]  IN_RST     = IN_RESET[IN_WIDTH-1:0];
    localparam logic [OUT_WIDTH-1:0] OUT_RST    = OUT_RESET[OUT_WIDTH-1:0];
    localparam logic [31:0]          ID_VALUE   = {16'hC10A, 8'(OUT_WIDTH), 8'(IN_WIDTH)};

    addr_e                               addr;
    logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_q;
    logic [IN_WIDTH-1:0]                 sync;
    logic [PRESC_W-1:0]                  presc;
    logic                                tick;
    logic [IN_WIDTH-1:0]                 samp;
    logic [IN_WIDTH-1:0]                 deb;
    logic [IN_WIDTH-1:0]                 deb_next;
    logic [IN_WIDTH-1:0]                 agree;
    logic [IN_WIDTH-1:0]                 edge_event;
    logic [IN_WIDTH-1:0]                 cap;
    logic [IN_WIDTH-1:0]                 mask;
    logic [IN_WIDTH-1:0]                 mode;
    logic [IN_WIDTH-1:0]                 w1c;
    logic [IN_WIDTH-1:0]                 wd_in;
    logic [OUT_WIDTH-1:0]                wd_out;
    logic [31:0]                         rd_mux;
    logic                                unused_wd;

    assign addr      = addr_e'(avs_address);
    assign wd_in     = avs_writedata[IN_WIDTH-1:0];
    assign wd_out    = avs_writedata[OUT_WIDTH-1:0];
    // Upper write-data bits beyond the bank widths are deliberately ignored.
    assign unused_wd = ^avs_writedata;

    assign sync = sync_q[SYNC_STAGES-1];
    assign tick = (presc == PRESC_LAST);

    // A bit only moves once two consecutive ticks see the same synchronized level.
    assign agree    = ~(sync ^ samp);
    assign deb_next = (agree & sync) | (~agree & deb);

    // Polarity-qualified change of the debounced value, only on a tick.
    assign edge_event = tick ? ((mode & deb_next & ~deb) | (~mode & ~deb_next & deb)) : '0;

    // Write-one-to-clear pattern for the capture register.
    assign w1c = (avs_write && addr == ADDR_EDGE_CAPTURE) ? wd_in : '0;

    // Multi-stage synchronizer for the raw asynchronous inputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset_reset_n) begin
            sync_q <= {SYNC_STAGES{IN_RST}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pio_in};
        end
    end

    // Free-running prescaler producing the debounce sample tick.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Debounce sample and debounced value, updated on tick only.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            samp <= IN_RST;
            deb  <= IN_RST;
        end else if (tick) begin
            samp <= sync;
            deb  <= deb_next;
        end
    end

    // Sticky edge capture; a same-cycle event beats the clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cap <= '0;
        end else begin
            cap <= (cap & ~w1c) | edge_event;
        end
    end

    // Software-writable mask, edge mode and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask    <= '0;
            mode    <= '0;
            pio_out <= OUT_RST;
        end else if (avs_write) begin
            case (addr)
                ADDR_DATA_OUT:  pio_out <= wd_out;
                ADDR_OUT_SET:   pio_out <= pio_out | wd_out;
                ADDR_OUT_CLR:   pio_out <= pio_out & ~wd_out;
                ADDR_IRQ_MASK:  mask    <= wd_in;
                ADDR_EDGE_MODE: mode    <= wd_in;
                default: ;
            endcase
        end
    end

    // Registered level interrupt from enabled captured edges.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(cap & mask);
        end
    end

    // Read multiplexer; write-only and unused bits read as zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd_mux unassigned,
        // which would otherwise infer a latch.
        rd_mux = '0;
        case (addr)
            ADDR_DATA_IN:      rd_mux = 32'(deb);
            ADDR_DATA_OUT:     rd_mux = 32'(pio_out);
            ADDR_IRQ_MASK:     rd_mux = 32'(mask);
            ADDR_EDGE_CAPTURE: rd_mux = 32'(cap);
            ADDR_EDGE_MODE:    rd_mux = 32'(mode);
            ADDR_ID:           rd_mux = ID_VALUE;
            default:           rd_mux = '0;
        endcase
    end

    // Fixed latency-1 read data, held until the next read.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avmm_debounced_pio.sv
// Self-checking bench for avmm_debounced_pio: register-map vector table,
// hand-written debounce / interrupt / reset corner cases, and randomized
// input and register traffic against a behavioural model.
module tb_avmm_debounced_pio;

    localparam int IN_W  = 18;
    localparam int OUT_W = 32;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    logic              clk_clk       = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic [2:0]        avs_address   = '0;
    logic              avs_read      = 1'b0;
    logic              avs_write     = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              irq;
    logic [IN_W-1:0]   pio_in        = '1;
    logic [OUT_W-1:0]  pio_out;

    int checks = 0;
    int errors = 0;

    avmm_debounced_pio #(
        .IN_WIDTH       (IN_W),
        .OUT_WIDTH      (OUT_W),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .IN_RESET       (32'h0003_FFFF),
        .OUT_RESET      (32'h0)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq),
        .pio_in       (pio_in),
        .pio_out      (pio_out)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // One bus cycle; read data is sampled on the following falling edge.
    task automatic bus(input logic wr, input logic rd, input logic [2:0] a,
                       input logic [31:0] d, output logic [31:0] rdata);
        @(negedge clk_clk);
        avs_write     = wr;
        avs_read      = rd;
        avs_address   = a;
        avs_writedata = d;
        @(negedge clk_clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        rdata     = avs_readdata;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, 1'b0, a, d, dummy);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] r);
        bus(1'b0, 1'b1, a, 32'h0, r);
    endtask

    function automatic vec_t mk(logic wr, logic rd, logic [2:0] a, logic [31:0] wd,
                                logic [31:0] er, logic [31:0] eo);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_out = eo;
        return v;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [31:0] r;
        logic [31:0] d;
        logic [31:0] rnd;
        logic        seen;
        logic        found;
        logic        prev_irq;
        logic [IN_W-1:0]  exp_deb, exp_cap, exp_mask, exp_mode, nin, rise, fall;
        logic [OUT_W-1:0] exp_out;

        // ---------------- reset ----------------
        pio_in        = '1;
        reset_reset_n = 1'b0;
        idle(3);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        idle(2);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pio_out", pio_out, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);

        // ---------------- register map table ----------------
        tbl.push_back(mk(0, 1, 3'd0, 32'h0,        32'h0003_FFFF, 32'h0));
        tbl.push_back(mk(0, 1, 3'd5, 32'h0,        32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 3'd7, 32'h0,        32'hC10A_2012, 32'h0));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0,        32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 3'd1, 32'h0000_00F0, 32'h0,        32'hF0));
        tbl.push_back(mk(1, 0, 3'd2, 32'h0000_000F, 32'h0,        32'hFF));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0,        32'hFF,        32'hFF));
        tbl.push_back(mk(1, 0, 3'd3, 32'h0000_0030, 32'h0,        32'hCF));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0,        32'hCF,        32'hCF));
        tbl.push_back(mk(0, 1, 3'd2, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(0, 1, 3'd3, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(1, 0, 3'd0, 32'h0000_1234, 32'h0,        32'hCF));
        tbl.push_back(mk(0, 1, 3'd0, 32'h0,        32'h0003_FFFF, 32'hCF));
        tbl.push_back(mk(1, 0, 3'd7, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(0, 1, 3'd7, 32'h0,        32'hC10A_2012, 32'hCF));
        tbl.push_back(mk(1, 0, 3'd4, 32'hFFFF_FFFF, 32'h0,        32'hCF));
        tbl.push_back(mk(0, 1, 3'd4, 32'h0,        32'h0003_FFFF, 32'hCF));
        tbl.push_back(mk(1, 0, 3'd6, 32'hFFFF_FFFF, 32'h0,        32'hCF));
        tbl.push_back(mk(0, 1, 3'd6, 32'h0,        32'h0003_FFFF, 32'hCF));
        tbl.push_back(mk(1, 0, 3'd6, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(0, 1, 3'd6, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(1, 0, 3'd4, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(0, 1, 3'd4, 32'h0,        32'h0,         32'hCF));
        tbl.push_back(mk(1, 1, 3'd1, 32'h0000_0055, 32'hCF,       32'h55));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0,        32'h55,        32'h55));

        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, r);
            if (tbl[i].rd) check($sformatf("vec%0d_rd", i), r, tbl[i].exp_rd);
            check($sformatf("vec%0d_out", i), pio_out, tbl[i].exp_out);
        end

        // Read data holds until the next read.
        rd_reg(3'd7, r);
        idle(3);
        check("rd_hold", avs_readdata, 32'hC10A_2012);

        // ---------------- glitch rejection ----------------
        wr_reg(3'd6, 32'h0);
        wr_reg(3'd4, 32'h1);
        wr_reg(3'd5, 32'hFFFF_FFFF);
        @(negedge clk_clk);
        pio_in[0] = 1'b0;
        idle(3);
        pio_in[0] = 1'b1;
        idle(20);
        rd_reg(3'd0, r);
        check("glitch_data", r, 32'h0003_FFFF);
        rd_reg(3'd5, r);
        check("glitch_cap", r, 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        // ---------------- 12-clock low pulse is accepted ----------------
        @(negedge clk_clk);
        pio_in[0]   = 1'b0;
        seen        = 1'b0;
        avs_address = 3'd0;
        avs_read    = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_clk);
            if (avs_readdata[0] === 1'b0) seen = 1'b1;
            if (c == 11) pio_in[0] = 1'b1;
        end
        avs_read = 1'b0;
        check("deb_latency", 32'(seen), 32'h1);
        idle(20);
        rd_reg(3'd5, r);
        check("fall_cap", r, 32'h1);
        check("fall_irq", 32'(irq), 32'h1);
        rd_reg(3'd0, r);
        check("fall_data_back", r, 32'h0003_FFFF);

        // ---------------- W1C drops irq on the following cycle ----------------
        @(negedge clk_clk);
        avs_write     = 1'b1;
        avs_address   = 3'd5;
        avs_writedata = 32'h1;
        @(negedge clk_clk);
        avs_write = 1'b0;
        check("irq_w1c_lag", 32'(irq), 32'h1);
        @(negedge clk_clk);
        check("irq_w1c_clear", 32'(irq), 32'h0);
        rd_reg(3'd5, r);
        check("w1c_cap", r, 32'h0);

        // ---------------- irq rises one cycle after cap ----------------
        @(negedge clk_clk);
        pio_in[0]   = 1'b0;
        avs_address = 3'd5;
        avs_read    = 1'b1;
        found       = 1'b0;
        prev_irq    = irq;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk_clk);
            if (avs_readdata[0] === 1'b1) found = 1'b1;
            else prev_irq = irq;
        end
        avs_read = 1'b0;
        check("cap_seen", 32'(found), 32'h1);
        check("irq_rise", 32'(irq), 32'h1);
        check("irq_one_cycle_late", 32'(prev_irq), 32'h0);
        pio_in[0] = 1'b1;
        idle(20);
        wr_reg(3'd5, 32'hFFFF_FFFF);
        idle(2);

        // ---------------- event vs W1C in the same cycle ----------------
        // Clearing every cycle: bit 0 can only ever read back set if the
        // event wins against the simultaneous clear.
        @(negedge clk_clk);
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        avs_address   = 3'd5;
        avs_writedata = 32'h1;
        pio_in[0]     = 1'b0;
        found         = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk_clk);
            if (avs_readdata[0] === 1'b1) found = 1'b1;
        end
        check("setwin_cap", 32'(found), 32'h1);
        check("setwin_irq", 32'(irq), 32'h1);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        pio_in[0] = 1'b1;
        idle(20);
        wr_reg(3'd5, 32'hFFFF_FFFF);

        // ---------------- asynchronous reset mid-operation ----------------
        @(negedge clk_clk);
        pio_in[0] = 1'b0;
        pio_in[2] = 1'b0;
        idle(20);
        rd_reg(3'd5, r);
        check("cap_pre_reset", r, 32'h5);
        wr_reg(3'd1, 32'hAA);
        wr_reg(3'd4, 32'h5);
        idle(2);
        check("irq_pre_reset", 32'(irq), 32'h1);
        check("out_pre_reset", pio_out, 32'hAA);
        pio_in[1] = 1'b0;
        idle(5);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("rst_async_irq", 32'(irq), 32'h0);
        check("rst_async_out", pio_out, 32'h0);
        check("rst_async_rdata", avs_readdata, 32'h0);
        pio_in = '1;
        idle(3);
        reset_reset_n = 1'b1;
        idle(2);
        rd_reg(3'd5, r);
        check("post_rst_cap", r, 32'h0);
        rd_reg(3'd4, r);
        check("post_rst_mask", r, 32'h0);
        rd_reg(3'd0, r);
        check("post_rst_data", r, 32'h0003_FFFF);

        // ---------------- randomized traffic vs behavioural model ----------------
        exp_deb  = '1;
        exp_cap  = '0;
        exp_mask = '0;
        exp_mode = '0;
        exp_out  = '0;
        for (int rnd_i = 0; rnd_i < 30; rnd_i++) begin
            for (int op = 0; op < 2; op++) begin
                d = $urandom;
                case ($urandom_range(0, 5))
                    0: begin wr_reg(3'd1, d); exp_out  = d; end
                    1: begin wr_reg(3'd2, d); exp_out  = exp_out | d; end
                    2: begin wr_reg(3'd3, d); exp_out  = exp_out & ~d; end
                    3: begin wr_reg(3'd4, d); exp_mask = d[IN_W-1:0]; end
                    4: begin wr_reg(3'd6, d); exp_mode = d[IN_W-1:0]; end
                    default: begin wr_reg(3'd5, d); exp_cap = exp_cap & ~d[IN_W-1:0]; end
                endcase
            end
            rnd = $urandom;
            nin = rnd[IN_W-1:0];
            @(negedge clk_clk);
            pio_in = nin;
            rise    = nin & ~exp_deb;
            fall    = exp_deb & ~nin;
            exp_cap = exp_cap | (exp_mode & rise) | (~exp_mode & fall);
            exp_deb = nin;
            idle(20);
            rd_reg(3'd0, r);
            check($sformatf("rnd%0d_data", rnd_i), r, 32'(exp_deb));
            rd_reg(3'd5, r);
            check($sformatf("rnd%0d_cap", rnd_i), r, 32'(exp_cap));
            rd_reg(3'd4, r);
            check($sformatf("rnd%0d_mask", rnd_i), r, 32'(exp_mask));
            check($sformatf("rnd%0d_out", rnd_i), pio_out, exp_out);
            check($sformatf("rnd%0d_irq", rnd_i), 32'(irq), 32'(|(exp_cap & exp_mask)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avmm_debounced_pio.md
Name: avmm_debounced_pio

Overview:
- Parametrised Avalon-MM parallel I/O peripheral for the Nios II system. It is the next-generation replacement for the separate LEDR/LEDG/HEX/KEY/SW PIO instances.
- One instance serves a single input bank and a single output bank of configurable width.
- Inputs get a synchronizer, a prescaled debouncer, per-bit edge capture with per-bit edge polarity, and a maskable interrupt.
- Outputs get atomic set/clear registers.

Parameters:
- IN_WIDTH, 18: number of input bits, 1..32.
- OUT_WIDTH, 32: number of output bits, 1..32.
- DEBOUNCE_CYCLES, 50000: clocks between debounce samples, >=1 (1 ms at 50 MHz).
- SYNC_STAGES, 2: input synchronizer depth, >=2.
- IN_RESET, 0: reset value of the synchronizer, sample and debounced registers. Set all-ones for active-low keys.
- OUT_RESET, 0: reset value of pio_out.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word register index
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed latency 1
- irq  out  1  level interrupt to the CPU
- pio_in  in  IN_WIDTH  raw asynchronous inputs
- pio_out  out  OUT_WIDTH  registered outputs

Behaviour:
- One clock domain. Reset is asynchronous active-low on every flop; release is synchronous to clk_clk.
- Reset values:
  - avs_readdata=0, irq=0, pio_out=OUT_RESET.
  - Mask, edge capture and edge mode = 0.
  - Prescaler = 0.
  - Synchronizer, sample and debounced registers = IN_RESET, so no edge is captured at reset release.
- Synchronizer: SYNC_STAGES flops per bit. sync is the last stage.
- Prescaler: counts 0..DEBOUNCE_CYCLES-1 and wraps. tick=1 when count==DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1, tick is high every cycle.
- Debounce, on tick only:
  - samp<=sync.
  - deb[i]<=sync[i] if sync[i]==samp[i], else deb[i] holds.
  - A change therefore needs two consecutive agreeing ticks. Any pulse shorter than DEBOUNCE_CYCLES clocks that is seen by at most one tick is rejected.
- Edge capture:
  - An event on bit i is a deb[i] update with new!=old, in the polarity selected by mode[i] (1=rising, 0=falling).
  - An event sets cap[i]; cap[i] is sticky.
  - Writing 1s to EDGE_CAPTURE clears those bits.
  - If an event and a W1C hit the same bit in the same cycle, the set wins.
- irq: registered, irq<=|(cap & mask). It rises one cycle after cap or mask changes.
- Register map, by avs_address:
  - 0 DATA_IN: read-only, returns deb.
  - 1 DATA_OUT: R/W, write replaces pio_out.
  - 2 OUT_SET: write-only, pio_out|=wd.
  - 3 OUT_CLR: write-only, pio_out&=~wd.
  - 4 IRQ_MASK: R/W.
  - 5 EDGE_CAPTURE: read returns cap; write is W1C.
  - 6 EDGE_MODE: R/W.
  - 7 ID: read-only, {16'hC10A, OUT_WIDTH[7:0], IN_WIDTH[7:0]}.
- Width rules:
  - Registers are truncated to IN_WIDTH or OUT_WIDTH; upper writedata bits are ignored.
  - Unimplemented bits read 0.
  - Writes to read-only addresses, and reads of addresses 2 and 3, have no effect and return 0.
- Bus timing:
  - No waitrequest; every access completes in one cycle.
  - Read: avs_readdata is registered from the address in the cycle avs_read is high, valid the next cycle, and held until the next read.
  - Reads have no side effects.
  - If avs_read and avs_write are both high, the write executes and the read returns the pre-write value.
- Writes take effect on the clock edge of the write cycle; pio_out changes one cycle later.
- Reset mid-operation: all state returns to its reset values immediately. The prescaler restarts from 0 and pending captures are lost.

Test Plan:
- Reset with IN_RESET=18'h3FFFF, pio_in all-ones -> after release irq=0, DATA_IN reads 0x3FFFF, EDGE_CAPTURE reads 0, ID reads 0xC10A2012, pio_out=0.
- DEBOUNCE_CYCLES=4; pulse pio_in[0] low for 3 clocks -> DATA_IN bit0 stays 1, no capture. Hold it low for 12 clocks -> bit0 reads 0 within 2*4+SYNC_STAGES+4 clocks.
- EDGE_MODE=0, IRQ_MASK=1, falling edge on bit0 -> EDGE_CAPTURE=0x1, irq=1 one cycle later. Write 0x1 to EDGE_CAPTURE -> cap=0, irq=0 the following cycle.
- Write DATA_OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30 -> pio_out=0xFF, then 0xCF; a DATA_OUT read returns 0xCF.
- Force a debounced edge in the same cycle as a W1C of that bit -> cap bit remains 1, irq stays 1.
- Assert reset_reset_n low mid-debounce with cap=0x5 and pio_out=0xAA -> cap=0, irq=0, pio_out=OUT_RESET immediately, without waiting for a clock edge.
